// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for Sobel: two line buffers plus a column history,
// emitting one registered window per interior pixel with its centre coordinates.
module sobel_window_gen #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned HEIGHT = 128,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CW     = 7
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  input  logic                  in_sof,
  output logic [9*DATA_W-1:0]   win_data,
  output logic                  win_valid,
  output logic [CW-1:0]         win_x,
  output logic [CW-1:0]         win_y,
  output logic                  frame_done
);

  localparam int unsigned AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Position counters of the next incoming pixel
  logic [CW-1:0] r_col, r_row;
  logic [CW-1:0] w_col, w_row;
  logic [CW-1:0] w_col_nxt, w_row_nxt;
  logic [AW-1:0] w_addr;
  logic          w_last_col, w_last_row;
  logic          w_issue;

  // Line buffers: lb0 holds the previous row, lb1 the row before it
  logic [DATA_W-1:0] r_lb0 [WIDTH];
  logic [DATA_W-1:0] r_lb1 [WIDTH];
  logic [DATA_W-1:0] w_lb0_rd, w_lb1_rd;

  // Two previous columns; the third (rightmost) column is the one arriving this cycle.
  // Each column packs top at the LSBs, bottom at the MSBs.
  logic [3*DATA_W-1:0] r_sh_l, r_sh_m;
  logic [3*DATA_W-1:0] w_new_col;
  logic [9*DATA_W-1:0] w_win;

  logic [9*DATA_W-1:0] r_win_data;
  logic                r_win_valid;
  logic [CW-1:0]       r_win_x, r_win_y;
  logic                r_frame_done;

  // in_sof relabels the current pixel as (0,0) regardless of the counters
  always_comb begin
    w_col = in_sof ? '0 : r_col;
    w_row = in_sof ? '0 : r_row;
  end

  assign w_addr     = w_col[AW-1:0];
  assign w_last_col = (w_col == CW'(WIDTH - 1));
  assign w_last_row = (w_row == CW'(HEIGHT - 1));
  assign w_issue    = (w_col >= CW'(2)) && (w_row >= CW'(2));

  always_comb begin
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_last_col) begin
      w_col_nxt = '0;
      w_row_nxt = w_last_row ? '0 : (w_row + CW'(1));
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pix_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // Read-before-write: reads use the pre-edge contents at the same address
  assign w_lb0_rd = r_lb0[w_addr];
  assign w_lb1_rd = r_lb1[w_addr];

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_lb0[w_addr] <= pix_in;
      r_lb1[w_addr] <= w_lb0_rd;
    end
  end

  assign w_new_col = {pix_in, w_lb0_rd, w_lb1_rd};

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_sh_l <= '0;
      r_sh_m <= '0;
    end else if (pix_valid) begin
      r_sh_l <= r_sh_m;
      r_sh_m <= w_new_col;
    end
  end

  always_comb begin
    w_win = '0;
    for (int r = 0; r < 3; r++) begin
      w_win[(r*3+0)*DATA_W +: DATA_W] = r_sh_l[r*DATA_W +: DATA_W];
      w_win[(r*3+1)*DATA_W +: DATA_W] = r_sh_m[r*DATA_W +: DATA_W];
      w_win[(r*3+2)*DATA_W +: DATA_W] = w_new_col[r*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_win_data   <= '0;
      r_win_valid  <= 1'b0;
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= pix_valid && w_issue;
      r_frame_done <= pix_valid && w_last_col && w_last_row;
      if (pix_valid && w_issue) begin
        r_win_data <= w_win;
        r_win_x    <= w_col - CW'(1);
        r_win_y    <= w_row - CW'(1);
      end
    end
  end

  assign win_data   = r_win_data;
  assign win_valid  = r_win_valid;
  assign win_x      = r_win_x;
  assign win_y      = r_win_y;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: an 8x6 instance driven from vector tables and a
// default 128x128 instance driven with a full ramp frame.
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [71:0] win_data;
  logic        win_valid;
  logic [2:0]  win_x, win_y;
  logic        frame_done;

  logic [7:0]  b_pix_in = '0;
  logic        b_pix_valid = 1'b0;
  logic        b_in_sof = 1'b0;
  logic [71:0] b_win_data;
  logic        b_win_valid;
  logic [6:0]  b_win_x, b_win_y;
  logic        b_frame_done;

  always #5 clk = ~clk;

  sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .CW(3)) dut (
    .clk(clk), .xrst(xrst), .pix_in(pix_in), .pix_valid(pix_valid), .in_sof(in_sof),
    .win_data(win_data), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .frame_done(frame_done)
  );

  sobel_window_gen dutb (
    .clk(clk), .xrst(xrst), .pix_in(b_pix_in), .pix_valid(b_pix_valid), .in_sof(b_in_sof),
    .win_data(b_win_data), .win_valid(b_win_valid), .win_x(b_win_x), .win_y(b_win_y),
    .frame_done(b_frame_done)
  );

  typedef struct {
    logic [7:0]  pix;
    bit          valid;
    bit          sof;
    bit          exp_wv;
    bit          exp_done;
    int          exp_x;
    int          exp_y;
    logic [71:0] exp_data;
  } vec_t;

  vec_t        tbl[$];
  logic [71:0] obs[$];
  logic [71:0] m_last;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [7:0] img(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'(r * 8 + c);
      1:       return 8'(255 - (r * 8 + c));
      default: return 8'(r + c);
    endcase
  endfunction

  // Window whose bottom-right tap is (r,c)
  function automatic logic [71:0] win_of(input int kind, input int r, input int c);
    logic [71:0] d;
    d = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        d[(i*3+j)*8 +: 8] = img(kind, r - 2 + i, c - 2 + j);
    return d;
  endfunction

  function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_px(input int kind, input int r, input int c, input bit sof,
                        input int gapmax);
    vec_t v;
    int   g;
    g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    for (int k = 0; k < g; k++) begin
      v = '{pix: 8'($urandom), valid: 1'b0, sof: 1'($urandom_range(0, 1)), exp_wv: 1'b0,
            exp_done: 1'b0, exp_x: 0, exp_y: 0, exp_data: m_last};
      tbl.push_back(v);
    end
    v.pix      = img(kind, r, c);
    v.valid    = 1'b1;
    v.sof      = sof;
    v.exp_wv   = (r >= 2) && (c >= 2);
    v.exp_done = (r == H - 1) && (c == W - 1);
    v.exp_x    = c - 1;
    v.exp_y    = r - 1;
    if (v.exp_wv) m_last = win_of(kind, r, c);
    v.exp_data = m_last;
    tbl.push_back(v);
  endtask

  task automatic add_frame(input int kind, input bit sof_first, input int gapmax);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        add_px(kind, r, c, sof_first && (r == 0) && (c == 0), gapmax);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      pix_in    = tbl[i].pix;
      pix_valid = tbl[i].valid;
      in_sof    = tbl[i].sof;
      @(posedge clk);
      #1;
      chk("win_valid", 72'(win_valid), 72'(tbl[i].exp_wv));
      chk("frame_done", 72'(frame_done), 72'(tbl[i].exp_done));
      if (tbl[i].exp_wv) begin
        chk("win_x", 72'(win_x), 72'(tbl[i].exp_x));
        chk("win_y", 72'(win_y), 72'(tbl[i].exp_y));
        chk("win_data", win_data, tbl[i].exp_data);
        obs.push_back(win_data);
      end else begin
        chk("win_data_hold", win_data, tbl[i].exp_data);
      end
    end
    pix_valid = 1'b0;
    in_sof    = 1'b0;
    tbl.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 72'(win_valid), 72'(0));
    chk({nm, "_data"}, win_data, 72'(0));
    chk({nm, "_x"}, 72'(win_x), 72'(0));
    chk({nm, "_y"}, 72'(win_y), 72'(0));
    chk({nm, "_done"}, 72'(frame_done), 72'(0));
  endtask

  initial begin
    int b_wins, b_dones;
    m_last = '0;
    #1;
    chk_zero("reset");
    #11;
    xrst = 1'b1;

    // 1: single frame, continuous valid
    obs.delete();
    add_frame(0, 1'b0, 0);
    run_tbl();
    chk("t1_count", 72'(obs.size()), 72'(24));
    if (obs.size() == 24) begin
      chk("t1_first", obs[0], pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));
      chk("t1_last", obs[23], pack9(29, 30, 31, 37, 38, 39, 45, 46, 47));
    end

    // 2: same frame with random idle gaps (idle cycles also toggle in_sof)
    obs.delete();
    add_frame(0, 1'b0, 3);
    run_tbl();
    chk("t2_count", 72'(obs.size()), 72'(24));

    // 3: back-to-back frames, second one inverted
    obs.delete();
    add_frame(0, 1'b0, 0);
    add_frame(1, 1'b0, 0);
    run_tbl();
    chk("t3_count", 72'(obs.size()), 72'(48));
    if (obs.size() == 48)
      chk("t3_f2_first", obs[24], pack9(255, 254, 253, 247, 246, 245, 239, 238, 237));

    // 4: partial frame abandoned by in_sof on its 21st pixel
    obs.delete();
    for (int p = 0; p < 20; p++) add_px(0, p / W, p % W, 1'b0, 0);
    add_frame(1, 1'b1, 0);
    run_tbl();
    chk("t4_count", 72'(obs.size()), 72'(2 + 24));

    // 5: asynchronous reset during row 3
    for (int p = 0; p < 3 * W + 4; p++) add_px(0, p / W, p % W, 1'b0, 0);
    run_tbl();
    chk("t5_pre_valid", 72'(win_valid), 72'(1));
    xrst = 1'b0;
    #1;
    chk_zero("t5_async");
    @(posedge clk);
    #2;
    xrst = 1'b1;
    m_last = '0;
    obs.delete();
    add_frame(0, 1'b0, 0);
    run_tbl();
    chk("t5_count", 72'(obs.size()), 72'(24));

    // 6: default 128x128 instance, pixel = (r+c)&255
    b_wins  = 0;
    b_dones = 0;
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        b_pix_in    = img(2, r, c);
        b_pix_valid = 1'b1;
        @(posedge clk);
        #1;
        if (b_frame_done) b_dones++;
        chk("big_valid", 72'(b_win_valid), 72'((r >= 2) && (c >= 2)));
        if (b_win_valid) begin
          b_wins++;
          chk("big_data", b_win_data, win_of(2, r, c));
        end
        if (r == 2 && c == 2) begin
          chk("big_first", b_win_data, pack9(0, 1, 2, 1, 2, 3, 2, 3, 4));
          chk("big_x", 72'(b_win_x), 72'(1));
          chk("big_y", 72'(b_win_y), 72'(1));
        end
      end
    end
    b_pix_valid = 1'b0;
    @(posedge clk);
    #1;
    if (b_frame_done) b_dones++;
    chk("big_valid_idle", 72'(b_win_valid), 72'(0));
    chk("big_wins", 72'(b_wins), 72'(15876));
    chk("big_dones", 72'(b_dones), 72'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
